// File: rtl/sram_ctrl.sv
// sram_ctrl: req/ack host to async-strobe SRAM initiator with programmable setup/pulse/hold timing.
// Define SRAM_CTRL_VERIFY_EN to add a read-back verify after every write (result on verr).
`timescale 1ns/1ps
module sram_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SETUP  = 1,
    parameter int PULSE  = 2,
    parameter int HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              verr,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              sram_cs,
    output logic              sram_wr,
    output logic              sram_rd
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;
    localparam logic [3:0] SETUP_C = 4'(SETUP - 1);
    localparam logic [3:0] PULSE_C = 4'(PULSE - 1);
    localparam logic [3:0] HOLD_C  = 4'(HOLD - 1);
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              we_q, busy_q, ack_q, cs_q, wr_q, rd_q, rd_phase;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q, rdata_q;
`ifdef SRAM_CTRL_VERIFY_EN
    logic              vfy_q, verr_q;
    logic [DATA_W-1:0] vrd_q;
    // verify pass of a write strobes rd, not wr
    assign rd_phase = !we_q || vfy_q;
    assign verr     = verr_q;
`else
    assign rd_phase = !we_q;
    assign verr     = 1'b0;
`endif
    assign busy      = busy_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign sram_addr = addr_q;
    assign sram_din  = din_q;
    assign sram_cs   = cs_q;
    assign sram_wr   = wr_q;
    assign sram_rd   = rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
`ifdef SRAM_CTRL_VERIFY_EN
            vfy_q   <= 1'b0;
            verr_q  <= 1'b0;
            vrd_q   <= '0;
`endif
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req) begin
                    state_q <= S_SETUP;
                    cnt_q   <= SETUP_C;
                    we_q    <= we;
                    busy_q  <= 1'b1;
                    cs_q    <= 1'b1;
                    addr_q  <= addr;
                    if (we) din_q <= wdata;
`ifdef SRAM_CTRL_VERIFY_EN
                    vfy_q   <= 1'b0;
`endif
                end
                S_SETUP: if (cnt_q == 4'd0) begin
                    state_q <= S_STROBE;
                    cnt_q   <= PULSE_C;
                    if (rd_phase) rd_q <= 1'b0;
                    else wr_q <= 1'b0;
                end else cnt_q <= cnt_q - 4'd1;
                S_STROBE: if (cnt_q == 4'd0) begin
                    state_q <= S_HOLD;
                    cnt_q   <= HOLD_C;
                    wr_q    <= 1'b1;
                    rd_q    <= 1'b1;
                    if (!we_q) rdata_q <= sram_dout;
`ifdef SRAM_CTRL_VERIFY_EN
                    if (vfy_q) vrd_q <= sram_dout;
`endif
                end else cnt_q <= cnt_q - 4'd1;
                S_HOLD: if (cnt_q == 4'd0) begin
`ifdef SRAM_CTRL_VERIFY_EN
                    if (we_q && !vfy_q) begin
                        state_q <= S_SETUP;
                        cnt_q   <= SETUP_C;
                        vfy_q   <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        ack_q   <= 1'b1;
                        verr_q  <= vfy_q && (vrd_q != din_q);
                    end
`else
                    state_q <= S_IDLE;
                    cs_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    ack_q   <= 1'b1;
`endif
                end else cnt_q <= cnt_q - 4'd1;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
